// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipelined core.
// This file holds the datapath widths, the ALU class codes and the bubble encoding.
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [1:0] UF_RTYPE = 2'b00;
  localparam logic [1:0] UF_IMM   = 2'b01;
  localparam logic [1:0] UF_MEM   = 2'b10;
  localparam logic [1:0] UF_BR    = 2'b11;

  // A bubble looks like an invalid R-type with function 0 and no destination.
  localparam logic [1:0] BUBBLE_USEFUNC = UF_RTYPE;
  localparam logic [3:0] BUBBLE_FUNC    = 4'b0000;

  // Only R-type and branch instructions read operand B from the register file.
  function automatic logic uses_reg_b(input logic [1:0] use_func);
    return (use_func == UF_RTYPE) || (use_func == UF_BR);
  endfunction

endpackage

// File: rtl/idex_hazard.sv
// Combinational hazard logic for the ID/EX boundary.
// It compares the ID sources against the instruction in EX to find load-use stalls and forwards.
module idex_hazard
  import pipe_pkg::*;
#(
  parameter int REG_W_P = REG_W
) (
  input  logic               idValid,
  input  logic [1:0]         idUseFunc,
  input  logic [REG_W_P-1:0] idRs,
  input  logic [REG_W_P-1:0] idRt,
  input  logic               exValid,
  input  logic               regWrite,
  input  logic               memRead,
  input  logic [REG_W_P-1:0] rd,
  output logic               loadUse,
  output logic               fwdANext,
  output logic               fwdBNext
);

  logic ex_writes;
  logic hit_rs;
  logic hit_rt;

  // r0 is hardwired to zero, so a write to it never creates a dependency.
  assign ex_writes = idValid & exValid & (rd != '0);
  assign hit_rs    = (rd == idRs);
  assign hit_rt    = (rd == idRt);

  assign loadUse  = ex_writes & memRead & (hit_rs | hit_rt);
  // A load result is not ready at EX/MEM, so a load never forwards from there.
  assign fwdANext = ex_writes & regWrite & ~memRead & hit_rs;
  assign fwdBNext = ex_writes & regWrite & ~memRead & hit_rt & uses_reg_b(idUseFunc);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 16-bit core.
// It handles load-use bubbles, branch flushes, the global hold and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_W_P  = REG_W,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idValid,
  input  logic [1:0]          idUseFunc,
  input  logic [3:0]          idFunc,
  input  logic [REG_W_P-1:0]  idRs,
  input  logic [REG_W_P-1:0]  idRt,
  input  logic [REG_W_P-1:0]  idDest,
  input  logic                idRegWrite,
  input  logic                idMemRead,
  input  logic [DATA_W_P-1:0] idDataA,
  input  logic [DATA_W_P-1:0] idDataB,
  input  logic [DATA_W_P-1:0] idImm,
  input  logic                exFlush,
  input  logic                hold,
  output logic [1:0]          useFunc,
  output logic [3:0]          func,
  output logic                fwdA,
  output logic                fwdB,
  output logic [DATA_W_P-1:0] dataA,
  output logic [DATA_W_P-1:0] dataB,
  output logic [DATA_W_P-1:0] imm,
  output logic [REG_W_P-1:0]  rd,
  output logic                regWrite,
  output logic                memRead,
  output logic                exValid,
  output logic                stallId,
  output logic [CNT_W-1:0]    bubbleCount
);

  logic load_use;
  logic fwd_a_next;
  logic fwd_b_next;

  idex_hazard #(.REG_W_P(REG_W_P)) u_hazard (
    .idValid   (idValid),
    .idUseFunc (idUseFunc),
    .idRs      (idRs),
    .idRt      (idRt),
    .exValid   (exValid),
    .regWrite  (regWrite),
    .memRead   (memRead),
    .rd        (rd),
    .loadUse   (load_use),
    .fwdANext  (fwd_a_next),
    .fwdBNext  (fwd_b_next)
  );

  // A flush or hold overrides the stall, so ID is only told to wait when a bubble really goes in.
  assign stallId = load_use & ~exFlush & ~hold;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, which the hazard compare relies on.
    if (rst || exFlush || (!hold && load_use)) begin
      exValid  <= 1'b0;
      regWrite <= 1'b0;
      memRead  <= 1'b0;
      useFunc  <= BUBBLE_USEFUNC;
      func     <= BUBBLE_FUNC;
      fwdA     <= 1'b0;
      fwdB     <= 1'b0;
      rd       <= '0;
      dataA    <= '0;
      dataB    <= '0;
      imm      <= '0;
    end else if (!hold) begin
      exValid  <= idValid;
      regWrite <= idRegWrite & idValid;
      memRead  <= idMemRead & idValid;
      useFunc  <= idUseFunc;
      func     <= idFunc;
      fwdA     <= fwd_a_next;
      fwdB     <= fwd_b_next;
      rd       <= idDest;
      dataA    <= idDataA;
      dataB    <= idDataB;
      imm      <= idImm;
    end
  end

  // Only load-use bubbles are counted; flush bubbles reflect branches, not hazards.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCount <= '0;
    end else if (!exFlush && !hold && load_use && (bubbleCount != '1)) begin
      bubbleCount <= bubbleCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage.
// A second instance with a 2-bit counter shares the stimulus and is used for the saturation case.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid;
  logic [1:0]  idUseFunc;
  logic [3:0]  idFunc;
  logic [3:0]  idRs, idRt, idDest;
  logic        idRegWrite, idMemRead;
  logic [15:0] idDataA, idDataB, idImm;
  logic        exFlush, hold;

  logic [1:0]  useFunc, useFunc_s;
  logic [3:0]  func, func_s;
  logic        fwdA, fwdB, fwdA_s, fwdB_s;
  logic [15:0] dataA, dataB, imm, dataA_s, dataB_s, imm_s;
  logic [3:0]  rd, rd_s;
  logic        regWrite, memRead, exValid, stallId;
  logic        regWrite_s, memRead_s, exValid_s, stallId_s;
  logic [15:0] bubbleCount;
  logic [1:0]  bubbleCount_s;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idUseFunc(idUseFunc), .idFunc(idFunc),
    .idRs(idRs), .idRt(idRt), .idDest(idDest), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
    .idDataA(idDataA), .idDataB(idDataB), .idImm(idImm), .exFlush(exFlush), .hold(hold),
    .useFunc(useFunc), .func(func), .fwdA(fwdA), .fwdB(fwdB), .dataA(dataA), .dataB(dataB),
    .imm(imm), .rd(rd), .regWrite(regWrite), .memRead(memRead), .exValid(exValid),
    .stallId(stallId), .bubbleCount(bubbleCount)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .idValid(idValid), .idUseFunc(idUseFunc), .idFunc(idFunc),
    .idRs(idRs), .idRt(idRt), .idDest(idDest), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
    .idDataA(idDataA), .idDataB(idDataB), .idImm(idImm), .exFlush(exFlush), .hold(hold),
    .useFunc(useFunc_s), .func(func_s), .fwdA(fwdA_s), .fwdB(fwdB_s), .dataA(dataA_s),
    .dataB(dataB_s), .imm(imm_s), .rd(rd_s), .regWrite(regWrite_s), .memRead(memRead_s),
    .exValid(exValid_s), .stallId(stallId_s), .bubbleCount(bubbleCount_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [1:0] uf, input logic [3:0] fn,
                        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] dst,
                        input logic rw, input logic mr, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] im);
    idValid = v; idUseFunc = uf; idFunc = fn; idRs = rs; idRt = rt; idDest = dst;
    idRegWrite = rw; idMemRead = mr; idDataA = a; idDataB = b; idImm = im;
    #1;
  endtask

  // Advance one edge and settle just past it, away from the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; exFlush = 1'b0; hold = 1'b0;
    @(negedge clk);
    set_id(1, UF_RTYPE, 4'h1, 4'd1, 4'd2, 4'd3, 1, 0, 16'h1111, 16'h2222, 16'h0000);
    tick(); tick();
    check("rst_exValid", exValid, 0);
    check("rst_useFunc", useFunc, 0);
    check("rst_rd", rd, 0);
    check("rst_dataA", dataA, 0);
    check("rst_regWrite", regWrite, 0);
    check("rst_stallId", stallId, 0);
    check("rst_count", bubbleCount, 0);
    rst = 1'b0;

    // add r3,r1,r2 then sub r4,r3,r5
    tick();
    check("add_exValid", exValid, 1);
    check("add_rd", rd, 3);
    check("add_dataA", dataA, 16'h1111);
    check("add_fwdA", fwdA, 0);
    set_id(1, UF_RTYPE, 4'h2, 4'd3, 4'd5, 4'd4, 1, 0, 16'hAAAA, 16'h5555, 16'h0000);
    check("sub_stall", stallId, 0);
    tick();
    check("sub_fwdA", fwdA, 1);
    check("sub_fwdB", fwdB, 0);
    check("sub_rd", rd, 4);
    check("sub_func", func, 2);

    // addi r2,r1,#7 with rt=r4: immediate class never forwards B
    set_id(1, UF_IMM, 4'h0, 4'd1, 4'd4, 4'd2, 1, 0, 16'h0001, 16'h0004, 16'h0007);
    tick();
    check("imm_fwdB_gated", fwdB, 0);
    check("imm_fwdA", fwdA, 0);
    check("imm_imm", imm, 16'h0007);

    // branch-class with rt=r2 forwards B; it names r0 as a written destination
    set_id(1, UF_BR, 4'h0, 4'd0, 4'd2, 4'd0, 1, 0, 16'h0000, 16'h0002, 16'h0010);
    tick();
    check("br_fwdB", fwdB, 1);
    check("br_fwdA", fwdA, 0);
    check("br_useFunc", useFunc, UF_BR);

    // rd == 0 and rs == 0: no forward
    set_id(1, UF_RTYPE, 4'h1, 4'd0, 4'd0, 4'd5, 1, 0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    check("r0_fwdA", fwdA, 0);
    check("r0_fwdB", fwdB, 0);

    // lw r6,4(r1) then add r7,r6,r1
    set_id(1, UF_MEM, 4'h0, 4'd1, 4'd6, 4'd6, 1, 1, 16'h0100, 16'h0000, 16'h0004);
    tick();
    check("lw_memRead", memRead, 1);
    set_id(1, UF_RTYPE, 4'h1, 4'd6, 4'd1, 4'd7, 1, 0, 16'h0066, 16'h0011, 16'h0000);
    check("lu_stall", stallId, 1);
    tick();
    check("lu_bubble_valid", exValid, 0);
    check("lu_bubble_uf", useFunc, 0);
    check("lu_bubble_rd", rd, 0);
    check("lu_bubble_rw", regWrite, 0);
    check("lu_count", bubbleCount, 1);
    check("lu_stall_drop", stallId, 0);
    set_id(1, UF_RTYPE, 4'h1, 4'd6, 4'd1, 4'd7, 1, 0, 16'h0067, 16'h0011, 16'h0000);
    tick();
    check("lu_add_valid", exValid, 1);
    check("lu_add_rd", rd, 7);
    check("lu_add_fwdA", fwdA, 0);
    check("lu_add_dataA", dataA, 16'h0067);

    // flush wins over load-use
    set_id(1, UF_MEM, 4'h0, 4'd1, 4'd8, 4'd8, 1, 1, 16'h0100, 16'h0000, 16'h0008);
    tick();
    set_id(1, UF_RTYPE, 4'h1, 4'd8, 4'd8, 4'd9, 1, 0, 16'h0088, 16'h0088, 16'h0000);
    exFlush = 1'b1; #1;
    check("flush_stall", stallId, 0);
    tick();
    exFlush = 1'b0;
    check("flush_valid", exValid, 0);
    check("flush_memRead", memRead, 0);
    check("flush_count", bubbleCount, 1);

    // hold with a pending load-use: EX frozen, no stall, no count
    set_id(1, UF_MEM, 4'h0, 4'd1, 4'd10, 4'd10, 1, 1, 16'h0100, 16'h0000, 16'h000A);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, UF_RTYPE, 4'(i + 3), 4'd10, 4'd2, 4'd11, 1, 0, 16'(16'h0B00 + i), 16'h0002, 16'h0000);
      check("hold_stall", stallId, 0);
      tick();
      check("hold_rd", rd, 10);
      check("hold_imm", imm, 16'h000A);
      check("hold_memRead", memRead, 1);
    end
    check("hold_count", bubbleCount, 1);
    hold = 1'b0; #1;
    check("unhold_stall", stallId, 1);
    tick();
    check("unhold_bubble", exValid, 0);
    check("unhold_count", bubbleCount, 2);
    tick();
    check("unhold_capture_rd", rd, 11);
    check("unhold_capture_dataA", dataA, 16'h0B02);
    check("unhold_capture_func", func, 5);

    // five more load-use stalls: 16-bit counter reaches 7, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_id(1, UF_MEM, 4'h0, 4'd1, 4'd12, 4'd12, 1, 1, 16'h0100, 16'h0000, 16'h000C);
      tick();
      set_id(1, UF_RTYPE, 4'h1, 4'd12, 4'd0, 4'd13, 1, 0, 16'h00CC, 16'h0000, 16'h0000);
      check("sat_stall", stallId, 1);
      tick();
    end
    check("sat_count16", bubbleCount, 7);
    check("sat_count2", bubbleCount_s, 3);

    // invalid ID gates regWrite/memRead
    set_id(0, UF_MEM, 4'h0, 4'd1, 4'd3, 4'd3, 1, 1, 16'h0000, 16'h0000, 16'h0000);
    tick();
    check("inv_valid", exValid, 0);
    check("inv_regWrite", regWrite, 0);
    check("inv_memRead", memRead, 0);

    // reset in the middle of a stall
    set_id(1, UF_MEM, 4'h0, 4'd1, 4'd6, 4'd6, 1, 1, 16'h0100, 16'h0000, 16'h0004);
    tick();
    set_id(1, UF_RTYPE, 4'h1, 4'd6, 4'd1, 4'd7, 1, 0, 16'h0066, 16'h0011, 16'h0000);
    check("rst_mid_stall_pre", stallId, 1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", exValid, 0);
    check("rst_mid_rd", rd, 0);
    check("rst_mid_count", bubbleCount, 0);
    check("rst_mid_stall", stallId, 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
